// File: rtl/uart_word_arbiter_pkg.sv
// Shared constants for the UART word arbiter: FSM encodings, byte width,
// the largest supported requester count and the round-robin pointer step.
package uart_word_arbiter_pkg;

  localparam int BYTE_W   = 8;
  localparam int MAX_NREQ = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Pointer position just after a granted index, wrapping to 0 past the last requester.
  function automatic logic [2:0] next_ptr(input logic [2:0] g, input int nreq);
    return (int'(g) == nreq - 1) ? 3'd0 : g + 3'd1;
  endfunction

endpackage

// File: rtl/uart_word_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NREQ. The pointer register itself lives in the caller.
module rr_arbiter
  import uart_word_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [2:0]      gnt_idx_o,
  output logic            any_o
);

  logic [MAX_NREQ-1:0] req_pad;
  logic [3:0]          idx;

  // Scan from the farthest candidate back to ptr so the nearest valid index wins last.
  always_comb begin
    req_pad   = MAX_NREQ'(req_i);
    idx       = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (req_pad[idx[2:0]]) begin
        gnt_idx_o = idx[2:0];
        any_o     = 1'b1;
      end
    end
  end

  // One-hot view of the chosen index.
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NREQ; i++) gnt_o[i] = any_o && (gnt_idx_o == 3'(i));
  end

endmodule

// File: rtl/uart_word_arbiter.sv
// Shares one uart_tx byte transmitter between NREQ word producers.
// Round-robin grant, word latched, then sent LSB byte first on the
// uart_tx en/data/busy handshake.
// Build option: define ARB_HEADER_EN to prefix each word with HDR_BASE | grant_id.
//
// Handshakes: a requester holds req_valid until its one-cycle req_ready pulse;
// the word is taken in the cycle where both are high. tx_en is a one-cycle strobe
// issued only while tx_busy is low; tx_data is valid with tx_en and held until the
// next tx_en.
module uart_word_arbiter
  import uart_word_arbiter_pkg::*;
#(
  parameter int         NREQ       = 2,
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] HDR_BASE   = 8'hA0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ*BYTE_W*WORD_BYTES-1:0] req_data,
  output logic [NREQ-1:0]                req_ready,
  output logic                           tx_en,
  output logic [7:0]                     tx_data,
  input  logic                           tx_busy,
  output logic [2:0]                     grant_id,
  output logic                           active,
  output logic [1:0]                     dbg_state
);

  localparam int W = BYTE_W * WORD_BYTES;
`ifdef ARB_HEADER_EN
  localparam logic [2:0] LAST = 3'(WORD_BYTES);
`else
  localparam logic [2:0] LAST = 3'(WORD_BYTES - 1);
  logic [7:0] unused_hdr_base;
  assign unused_hdr_base = HDR_BASE;
`endif

  logic [1:0]      state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [2:0]      grant_q, grant_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            live_q;

  logic [NREQ-1:0] gnt;
  logic [2:0]      gnt_idx;
  logic            gnt_any;
  logic [W-1:0]    gnt_word;
  logic [W-1:0]    shifted;
  logic [7:0]      cur_byte;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // Word of the requester currently being granted.
  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_word = req_data[i*W +: W];
  end

  // Byte selected by byte_cnt; with a header, slot 0 is the header.
  always_comb begin
    cur_byte = 8'h00;
    shifted  = '0;
`ifdef ARB_HEADER_EN
    if (byte_cnt_q == 3'd0) begin
      cur_byte = HDR_BASE | {5'b0, grant_q};
    end else begin
      shifted  = buf_q >> {byte_cnt_q - 3'd1, 3'b000};
      cur_byte = shifted[7:0];
    end
`else
    shifted  = buf_q >> {byte_cnt_q, 3'b000};
    cur_byte = shifted[7:0];
`endif
  end

  // FSM next state: grant in IDLE, strobe a byte in SEND, one blind cycle in GAP.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    req_ready  = '0;
    tx_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // live_q keeps req_ready quiet during and right out of reset.
        if (live_q && gnt_any) begin
          req_ready  = gnt;
          buf_d      = gnt_word;
          grant_d    = gnt_idx;
          ptr_d      = next_ptr(gnt_idx, NREQ);
          byte_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_en     = 1'b1;
          tx_data_d = cur_byte;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        // tx_busy rises a cycle after tx_en, so it is not consulted here.
        if (byte_cnt_q == LAST) begin
          state_d = ST_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          state_d    = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      live_q     <= 1'b1;
    end
  end

  assign tx_data   = tx_en ? cur_byte : tx_data_q;
  assign grant_id  = grant_q;
  assign active    = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_word_arbiter.sv
// Directed bench for uart_word_arbiter: a 2-requester instance for the main
// sequence and a 3-requester instance for pointer wrap. Each uart_tx is modelled
// as busy for 10 cycles starting the cycle after tx_en.
module tb_uart_word_arbiter;

  logic        clk;
  logic        rst_n;

  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [2:0]  grant_id;
  logic        active;
  logic [1:0]  dbg_state;

  logic [2:0]  r3_valid;
  logic [95:0] r3_data;
  logic [2:0]  r3_ready;
  logic        r3_tx_en;
  logic [7:0]  r3_tx_data;
  logic        r3_busy;
  logic [2:0]  r3_gid;
  logic        r3_active;
  logic [1:0]  r3_state;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap_cnt = 0;
  int busy_tx_cnt = 0;
  int busy_cnt = 0;
  int busy3_cnt = 0;
  logic force_busy;
  int stall_bad;

  logic [7:0] byte_q[$];
  logic [2:0] gid_q[$];
  logic [1:0] rdy_q[$];
  logic [7:0] exp_q[$];

  uart_word_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .dbg_state(dbg_state)
  );

  uart_word_arbiter #(.NREQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_data(r3_data),
    .req_ready(r3_ready), .tx_en(r3_tx_en), .tx_data(r3_tx_data), .tx_busy(r3_busy),
    .grant_id(r3_gid), .active(r3_active), .dbg_state(r3_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx models
  always @(posedge clk) begin
    if (tx_en) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (r3_tx_en) busy3_cnt <= 10;
    else if (busy3_cnt != 0) busy3_cnt <= busy3_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);
  assign r3_busy = (busy3_cnt != 0);

  // Monitor on the falling edge
  always @(negedge clk) begin
    if (tx_en) begin
      byte_q.push_back(tx_data);
      gid_q.push_back(grant_id);
    end
    if (req_ready != 2'b00) rdy_q.push_back(req_ready);
    if (tx_en && (req_ready != 2'b00)) overlap_cnt++;
    if (tx_en && tx_busy) busy_tx_cnt++;
    if (r3_tx_en && (r3_ready != 3'b000)) overlap_cnt++;
    if (r3_tx_en && r3_busy) busy_tx_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_queues();
    byte_q.delete();
    gid_q.delete();
    rdy_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_ready2(input string tag);
    int n = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && n < 300) begin @(negedge clk); n++; end
    check({tag, "_ready_seen"}, 32'(req_ready != 2'b00), 32'd1);
  endtask

  task automatic wait_ready3(input string tag);
    int n = 0;
    @(negedge clk);
    while (r3_ready == 3'b000 && n < 300) begin @(negedge clk); n++; end
    check({tag, "_ready_seen"}, 32'(r3_ready != 3'b000), 32'd1);
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    @(negedge clk);
    while (!tx_en && n < 300) begin @(negedge clk); n++; end
    check({tag, "_tx_seen"}, 32'(tx_en), 32'd1);
  endtask

  task automatic wait_idle2(input string tag);
    int n = 0;
    @(negedge clk);
    while (active && n < 500) begin @(negedge clk); n++; end
    check({tag, "_idle_seen"}, 32'(active), 32'd0);
  endtask

  task automatic wait_idle3(input string tag);
    int n = 0;
    @(negedge clk);
    while (r3_active && n < 500) begin @(negedge clk); n++; end
    check({tag, "_idle_seen"}, 32'(r3_active), 32'd0);
  endtask

  // Compare captured bytes against exp_q and every byte's grant against g.
  task automatic check_bytes(input string tag, input logic [2:0] g);
    check({tag, "_byte_count"}, 32'(byte_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(byte_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_gid%0d", tag, i), 32'(gid_q[i]), 32'(g));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    force_busy = 1'b0;
    req_valid = '0;
    req_data = '0;
    r3_valid = '0;
    r3_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1. Single word from req0; ptr 0 -> 1
    clear_queues();
    #1 req_valid = 2'b01; req_data[31:0] = 32'h44332211;
    wait_ready2("t1");
    check("t1_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    check("t1_first_tx_en", 32'(tx_en), 32'd1);
    check("t1_first_tx_data", 32'(tx_data), 32'h11);
    check("t1_grant_id", 32'(grant_id), 32'd0);
    repeat (33) @(negedge clk);
    check("t1_fourth_tx_en", 32'(tx_en), 32'd1);
    check("t1_fourth_tx_data", 32'(tx_data), 32'h44);
    @(negedge clk);
    check("t1_active_in_gap", 32'(active), 32'd1);
    @(negedge clk);
    check("t1_active_fall", 32'(active), 32'd0);
    @(posedge clk);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_bytes("t1", 3'd0);
    check("t1_ready_pulses", 32'(rdy_q.size()), 32'd1);
    repeat (15) @(posedge clk);

    // 2. Contention: ptr is 1, so grants go 1,0,1,0
    clear_queues();
    #1 req_data = {32'hB3B2B1B0, 32'hA3A2A1A0}; req_valid = 2'b11;
    begin
      int seen = 0;
      int n = 0;
      while (seen < 4 && n < 400) begin
        @(negedge clk); n++;
        if (req_ready != 2'b00) seen++;
      end
      check("t2_four_grants", 32'(seen), 32'd4);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle2("t2");
    @(posedge clk);
    check("t2_ready_pulses", 32'(rdy_q.size()), 32'd4);
    check("t2_byte_total", 32'(byte_q.size()), 32'd16);
    for (int w = 0; w < 4; w++) begin
      logic [2:0] g;
      g = (w % 2 == 0) ? 3'd1 : 3'd0;
      if (w < rdy_q.size())
        check($sformatf("t2_ready%0d", w), 32'(rdy_q[w]), (g == 3'd1) ? 32'd2 : 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (w*4 + k < byte_q.size()) begin
          check($sformatf("t2_w%0d_b%0d", w, k), 32'(byte_q[w*4+k]),
                (g == 3'd1) ? 32'hB0 + 32'(k) : 32'hA0 + 32'(k));
          check($sformatf("t2_w%0d_gid%0d", w, k), 32'(gid_q[w*4+k]), 32'(g));
        end
      end
    end
    repeat (15) @(posedge clk);

    // 3. Busy stall: ptr is 1, only req0 valid; last byte sent so far was A3
    clear_queues();
    #1 force_busy = 1'b1; req_data[31:0] = 32'h55667788; req_valid = 2'b01;
    wait_ready2("t3");
    @(posedge clk); #1 req_valid = 2'b00;
    stall_bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_en || tx_data !== 8'hA3) stall_bad++;
    end
    check("t3_stall_quiet", 32'(stall_bad), 32'd0);
    @(posedge clk); #1 force_busy = 1'b0;
    @(negedge clk);
    check("t3_tx_en_after_busy", 32'(tx_en), 32'd1);
    check("t3_tx_data_after_busy", 32'(tx_data), 32'h88);
    wait_idle2("t3");
    @(posedge clk);
    exp_q = '{8'h88, 8'h77, 8'h66, 8'h55};
    check_bytes("t3", 3'd0);
    repeat (15) @(posedge clk);

    // 4. Reset mid-word: req1 word cut after its second byte
    clear_queues();
    #1 req_data[63:32] = 32'h0D0C0B0A; req_valid = 2'b10;
    wait_ready2("t4");
    check("t4_ready", 32'(req_ready), 32'd2);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_tx("t4_b0");
    wait_tx("t4_b1");
    repeat (3) @(posedge clk);
    #1 req_data[31:0] = 32'h24232221; req_valid = 2'b11; rst_n = 1'b0;
    #1;
    check("t4_rst_req_ready", 32'(req_ready), 32'd0);
    check("t4_rst_tx_en", 32'(tx_en), 32'd0);
    check("t4_rst_tx_data", 32'(tx_data), 32'd0);
    check("t4_rst_grant_id", 32'(grant_id), 32'd0);
    check("t4_rst_active", 32'(active), 32'd0);
    check("t4_rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    clear_queues();
    #1 rst_n = 1'b1;
    wait_ready2("t4_post");
    check("t4_post_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    check("t4_post_grant_id", 32'(grant_id), 32'd0);
    wait_idle2("t4_post");
    @(posedge clk);
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24};
    check_bytes("t4", 3'd0);
    repeat (15) @(posedge clk);

    // 5. Header build (or plain word without the header): req1 sends DEADBEEF
    clear_queues();
    #1 req_data[63:32] = 32'hDEADBEEF; req_valid = 2'b10;
    wait_ready2("t5");
    @(posedge clk); #1 req_valid = 2'b00;
    check("t5_grant_id", 32'(grant_id), 32'd1);
    wait_idle2("t5");
    @(posedge clk);
`ifdef ARB_HEADER_EN
    exp_q = '{8'hA1, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`else
    exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`endif
    check_bytes("t5", 3'd1);
    repeat (15) @(posedge clk);

    // 6. Wrap on the 3-requester instance: req2 then req0 with req1 also pending
    #1 r3_data = {32'h32323232, 32'h31313131, 32'h30303030}; r3_valid = 3'b100;
    wait_ready3("t6_a");
    check("t6_a_ready", 32'(r3_ready), 32'd4);
    @(posedge clk); #1 r3_valid = 3'b000;
    check("t6_a_grant_id", 32'(r3_gid), 32'd2);
    wait_idle3("t6_a");
    @(posedge clk); #1 r3_valid = 3'b011;
    wait_ready3("t6_b");
    check("t6_b_ready", 32'(r3_ready), 32'd1);
    @(posedge clk); #1 r3_valid = 3'b000;
    check("t6_b_grant_id", 32'(r3_gid), 32'd0);
    wait_idle3("t6_b");
    repeat (15) @(posedge clk);

    // Protocol rules collected across the whole run
    check("never_ready_with_tx_en", 32'(overlap_cnt), 32'd0);
    check("never_tx_en_while_busy", 32'(busy_tx_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
